// File: rtl/csr_ctx_bank_pkg.sv
// Shared constants for the NoobsCpu control/status register bank:
// default widths, register bit positions, write-select codes and helpers.
package csr_ctx_bank_pkg;

  localparam int CR_W_DEF      = 8;
  localparam int SR_W_DEF      = 8;
  localparam int CTX_DEPTH_DEF = 4;

  // Default sticky set: SR_STOVF and SR_ITRP latch events until software clears them.
  localparam logic [7:0] STICKY_MASK_DEF = 8'h12;

  // Status register bit positions
  localparam int SR_OVF   = 0;
  localparam int SR_STOVF = 1;
  localparam int SR_NZ    = 2;
  localparam int SR_Z     = 3;
  localparam int SR_ITRP  = 4;

  // Control register bit positions
  localparam int CR_BCZ      = 0;
  localparam int CR_BCNZ     = 1;
  localparam int CR_SPMSB_LO = 2;
  localparam int CR_SPMSB_HI = 4;

  // Software write target select
  localparam logic SEL_CR = 1'b0;
  localparam logic SEL_SR = 1'b1;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width for a storage array of the given depth (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/csr_ctx_bank_if.sv
// Bus bundle between the CPU datapath (master) and the CSR bank (slave):
// HW flag updates, SW register writes, context push/pop and register readback.
interface csr_ctx_bank_if
  import csr_ctx_bank_pkg::*;
#(
  parameter int CR_W      = CR_W_DEF,
  parameter int SR_W      = SR_W_DEF,
  parameter int CTX_DEPTH = CTX_DEPTH_DEF
);

  localparam int DW = max_w(CR_W, SR_W);
  localparam int LW = $clog2(CTX_DEPTH + 1);

  logic [SR_W-1:0] hw_sr_val;
  logic [SR_W-1:0] hw_sr_en;
  logic [CR_W-1:0] hw_cr_val;
  logic [CR_W-1:0] hw_cr_en;
  logic            sw_wr;
  logic            sw_sel;
  logic [DW-1:0]   sw_data;
  logic [DW-1:0]   sw_mask;
  logic            ctx_push;
  logic            ctx_pop;
  logic [CR_W-1:0] creg;
  logic [SR_W-1:0] sreg;
  logic [LW-1:0]   ctx_level;
  logic            ctx_full;
  logic            ctx_empty;
  logic            ctx_err;

  modport master (
    output hw_sr_val, hw_sr_en, hw_cr_val, hw_cr_en,
    output sw_wr, sw_sel, sw_data, sw_mask, ctx_push, ctx_pop,
    input  creg, sreg, ctx_level, ctx_full, ctx_empty, ctx_err
  );

  modport slave (
    input  hw_sr_val, hw_sr_en, hw_cr_val, hw_cr_en,
    input  sw_wr, sw_sel, sw_data, sw_mask, ctx_push, ctx_pop,
    output creg, sreg, ctx_level, ctx_full, ctx_empty, ctx_err
  );

endinterface

// File: rtl/csr_ctx_bank_ctx_stack.sv
// LIFO context stack: DEPTH entries of {CR,SR}, occupancy counter with
// saturation at 0/DEPTH, and a sticky error flag for overflow, underflow
// and push/pop collisions. The top-of-stack entry is read combinationally
// so a return can restore the registers on the same edge.
module csr_ctx_bank_ctx_stack
  import csr_ctx_bank_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_push_data,
  output logic [W-1:0]               o_pop_data,
  output logic                       o_pop_ok,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = idx_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_level;
  logic          r_err;
  logic          w_push_ok;
  logic          w_err_evt;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_push_ok = i_push & ~i_pop & ~o_full;
  assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
  // Dropped requests (collision, push at full, pop at empty) all flag an error.
  assign w_err_evt = (i_push & i_pop) | (i_push & o_full) | (i_pop & o_empty);

  // Index is only used for writes when not full and reads when not empty,
  // so truncating the level to the array index width is safe.
  assign w_wr_idx   = IW'(r_level);
  assign w_rd_idx   = IW'(r_level - LW'(1));
  assign o_pop_data = r_mem[w_rd_idx];
  assign o_level    = r_level;
  assign o_err      = r_err;

  // Occupancy counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_level <= r_level + LW'(1);
      end else if (o_pop_ok) begin
        r_level <= r_level - LW'(1);
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stack storage; contents survive reset, only the level is cleared.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/csr_ctx_bank.sv
// NoobsCpu CSR bank: CR/SR registers with per-bit HW updates, masked SW
// writes, write-1-to-clear sticky status bits and a context stack for
// interrupt/trap entry and return.
// Build option CSR_BYPASS_EN: creg/sreg show the combinational next state
// (same-cycle forwarding for the branch unit); otherwise they are registered.
module csr_ctx_bank
  import csr_ctx_bank_pkg::*;
#(
  parameter int              CR_W        = CR_W_DEF,
  parameter int              SR_W        = SR_W_DEF,
  parameter int              CTX_DEPTH   = CTX_DEPTH_DEF,
  parameter logic [SR_W-1:0] STICKY_MASK = SR_W'(STICKY_MASK_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  csr_ctx_bank_if.slave bus
);

  logic [CR_W-1:0]      r_cr;
  logic [SR_W-1:0]      r_sr;
  logic [CR_W-1:0]      w_cr_swm;
  logic [SR_W-1:0]      w_sr_swm;
  logic [CR_W-1:0]      w_cr_norm;
  logic [SR_W-1:0]      w_sr_norm;
  logic [CR_W-1:0]      w_cr_next;
  logic [SR_W-1:0]      w_sr_next;
  logic [SR_W-1:0]      w_sticky_set;
  logic [CR_W+SR_W-1:0] w_pop_data;
  logic                 w_pop_ok;

  // Effective per-bit write masks; bits above the target width are ignored.
  assign w_cr_swm = (bus.sw_wr && bus.sw_sel == SEL_CR) ? bus.sw_mask[CR_W-1:0] : '0;
  assign w_sr_swm = (bus.sw_wr && bus.sw_sel == SEL_SR) ? bus.sw_mask[SR_W-1:0] : '0;
  assign w_sticky_set = STICKY_MASK & bus.hw_sr_en & bus.hw_sr_val;

  genvar gi;

  // CR: software write has priority over hardware update.
  for (gi = 0; gi < CR_W; gi++) begin : g_cr
    assign w_cr_norm[gi] = w_cr_swm[gi]       ? bus.sw_data[gi]   :
                           bus.hw_cr_en[gi]   ? bus.hw_cr_val[gi] : r_cr[gi];
  end

  // SR: hardware wins on plain bits; sticky bits are set by HW 1 and cleared
  // by SW write-1, with a same-cycle HW set beating the clear.
  for (gi = 0; gi < SR_W; gi++) begin : g_sr
    if (STICKY_MASK[gi]) begin : g_sticky
      assign w_sr_norm[gi] = (r_sr[gi] & ~(w_sr_swm[gi] & bus.sw_data[gi])) |
                             w_sticky_set[gi];
    end else begin : g_plain
      assign w_sr_norm[gi] = bus.hw_sr_en[gi] ? bus.hw_sr_val[gi] :
                             w_sr_swm[gi]     ? bus.sw_data[gi]   : r_sr[gi];
    end
  end

  csr_ctx_bank_ctx_stack #(
    .W     (CR_W + SR_W),
    .DEPTH (CTX_DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .i_push      (bus.ctx_push),
    .i_pop       (bus.ctx_pop),
    .i_push_data ({r_cr, r_sr}),
    .o_pop_data  (w_pop_data),
    .o_pop_ok    (w_pop_ok),
    .o_level     (bus.ctx_level),
    .o_full      (bus.ctx_full),
    .o_empty     (bus.ctx_empty),
    .o_err       (bus.ctx_err)
  );

  // Next-state select: reset, then context restore (sticky events still merged), then normal merge.
  always_comb begin
    w_cr_next = w_cr_norm;
    w_sr_next = w_sr_norm;
    if (reset) begin
      w_cr_next = '0;
      w_sr_next = '0;
    end else if (w_pop_ok) begin
      w_cr_next = w_pop_data[CR_W+SR_W-1:SR_W];
      w_sr_next = w_pop_data[SR_W-1:0] | w_sticky_set;
    end
  end

  // CR/SR state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cr <= '0;
      r_sr <= '0;
    end else begin
      r_cr <= w_cr_next;
      r_sr <= w_sr_next;
    end
  end

`ifdef CSR_BYPASS_EN
  assign bus.creg = w_cr_next;
  assign bus.sreg = w_sr_next;
`else
  assign bus.creg = r_cr;
  assign bus.sreg = r_sr;
`endif

endmodule

// File: tb/tb_csr_ctx_bank.sv
// Self-checking bench for csr_ctx_bank: directed scenarios followed by
// randomized traffic, all checked against a mask-arithmetic/queue model.
module tb_csr_ctx_bank;
  import csr_ctx_bank_pkg::*;

  localparam logic [7:0] STK   = 8'h12;
  localparam int         DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csr_ctx_bank_if bus_if ();

  csr_ctx_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;
  int n_tx     = 0;

  // Reference model state
  logic [7:0]  m_cr, m_sr;
  logic [15:0] m_stk[$];
  logic        m_err;
  // Predicted next state and stack action (0 none, 1 push, 2 pop, 3 error, 4 reset)
  logic [7:0]  n_cr, n_sr;
  int          n_act;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus_if.hw_sr_val = '0; bus_if.hw_sr_en = '0;
    bus_if.hw_cr_val = '0; bus_if.hw_cr_en = '0;
    bus_if.sw_wr = 1'b0; bus_if.sw_sel = 1'b0;
    bus_if.sw_data = '0; bus_if.sw_mask = '0;
    bus_if.ctx_push = 1'b0; bus_if.ctx_pop = 1'b0;
  endtask

  // Next state from the rules, expressed as whole-word mask arithmetic.
  function automatic void predict();
    logic [7:0] swcr, swsr, hset, plain, stick;
    logic [15:0] top;
    swcr = (bus_if.sw_wr && bus_if.sw_sel == SEL_CR) ? bus_if.sw_mask : 8'h00;
    swsr = (bus_if.sw_wr && bus_if.sw_sel == SEL_SR) ? bus_if.sw_mask : 8'h00;
    hset = bus_if.hw_sr_en & bus_if.hw_sr_val;
    n_cr = (m_cr & ~swcr & ~bus_if.hw_cr_en) |
           (bus_if.hw_cr_val & bus_if.hw_cr_en & ~swcr) |
           (bus_if.sw_data & swcr);
    plain = (m_sr & ~bus_if.hw_sr_en & ~swsr) | hset |
            (bus_if.sw_data & swsr & ~bus_if.hw_sr_en);
    stick = (m_sr & ~(swsr & bus_if.sw_data)) | hset;
    n_sr  = (plain & ~STK) | (stick & STK);
    n_act = 0;
    if (reset) begin
      n_cr = 8'h00; n_sr = 8'h00; n_act = 4;
    end else if (bus_if.ctx_push && bus_if.ctx_pop) begin
      n_act = 3;
    end else if (bus_if.ctx_push) begin
      n_act = (m_stk.size() == DEPTH) ? 3 : 1;
    end else if (bus_if.ctx_pop) begin
      if (m_stk.size() == 0) begin
        n_act = 3;
      end else begin
        top  = m_stk[$];
        n_cr = top[15:8];
        n_sr = top[7:0] | (STK & hset);
        n_act = 2;
      end
    end
  endfunction

  task automatic commit();
    case (n_act)
      1: m_stk.push_back({m_cr, m_sr});
      2: void'(m_stk.pop_back());
      3: m_err = 1'b1;
      4: begin m_stk.delete(); m_err = 1'b0; end
      default: ;
    endcase
    m_cr = n_cr;
    m_sr = n_sr;
  endtask

  // One clock transaction with inputs already driven; checks against the model.
  task automatic cycle(input string tag);
    predict();
`ifdef CSR_BYPASS_EN
    #1;
    chk({tag, ".byp_creg"}, 16'(bus_if.creg), 16'(n_cr));
    chk({tag, ".byp_sreg"}, 16'(bus_if.sreg), 16'(n_sr));
`endif
    @(posedge clk);
    #1;
    commit();
`ifndef CSR_BYPASS_EN
    chk({tag, ".creg"}, 16'(bus_if.creg), 16'(m_cr));
    chk({tag, ".sreg"}, 16'(bus_if.sreg), 16'(m_sr));
`endif
    chk({tag, ".level"}, 16'(bus_if.ctx_level), 16'(m_stk.size()));
    chk({tag, ".full"},  16'(bus_if.ctx_full),  16'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 16'(bus_if.ctx_empty), 16'(m_stk.size() == 0));
    chk({tag, ".err"},   16'(bus_if.ctx_err),   16'(m_err));
    n_tx++;
    $display("tx %0d %s: creg=%h sreg=%h level=%0d err=%0b",
             n_tx, tag, bus_if.creg, bus_if.sreg, bus_if.ctx_level, bus_if.ctx_err);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    clr();
    reset = 1'b1;
    cycle(tag);
    reset = 1'b0;
  endtask

  task automatic wr_cr(input logic [7:0] d);
    bus_if.sw_wr = 1'b1; bus_if.sw_sel = SEL_CR;
    bus_if.sw_data = d;  bus_if.sw_mask = 8'hFF;
  endtask

  initial begin
    m_cr = '0; m_sr = '0; m_err = 1'b0;
    reset = 1'b1;
    clr();
    @(negedge clk);

    // 1: reset state, HW flag update, reset clears
    do_reset("t1_rst");
    chk("t1_rst_empty", 16'(bus_if.ctx_empty), 16'h1);
    clr(); bus_if.hw_sr_en = 8'h09; bus_if.hw_sr_val = 8'h09; cycle("t1_hw");
`ifndef CSR_BYPASS_EN
    chk("t1_sreg09", 16'(bus_if.sreg), 16'h09);
`endif
    do_reset("t1_rst2");
`ifndef CSR_BYPASS_EN
    chk("t1_sreg0", 16'(bus_if.sreg), 16'h00);
`endif

    // 2: sticky ITRP bit: HW set beats same-cycle SW clear; clear alone works
    clr(); bus_if.hw_sr_en = 8'(1 << SR_ITRP); bus_if.hw_sr_val = 8'(1 << SR_ITRP); cycle("t2_set");
    bus_if.sw_wr = 1'b1; bus_if.sw_sel = SEL_SR; bus_if.sw_data = 8'h10; bus_if.sw_mask = 8'h10;
    cycle("t2_race");
`ifndef CSR_BYPASS_EN
    chk("t2_race_bit4", 16'(bus_if.sreg[SR_ITRP]), 16'h1);
`endif
    bus_if.hw_sr_en = '0; bus_if.hw_sr_val = '0; cycle("t2_clr");
`ifndef CSR_BYPASS_EN
    chk("t2_clr_bit4", 16'(bus_if.sreg[SR_ITRP]), 16'h0);
`endif
    // HW value 0 on a sticky bit never clears it
    clr(); bus_if.hw_sr_en = 8'h02; bus_if.hw_sr_val = 8'h02; cycle("t2_stovf");
    bus_if.hw_sr_val = 8'h00; cycle("t2_hw0");

    // 3: save, overwrite, restore
    do_reset("t3_rst");
    clr(); bus_if.hw_cr_en = 8'h0C; bus_if.hw_cr_val = 8'h0C;
    bus_if.hw_sr_en = 8'h08; bus_if.hw_sr_val = 8'h08; cycle("t3_load");
    clr(); bus_if.ctx_push = 1'b1; cycle("t3_push");
    chk("t3_level1", 16'(bus_if.ctx_level), 16'd1);
    clr(); wr_cr(8'h03); cycle("t3_wr");
    clr(); bus_if.ctx_pop = 1'b1; cycle("t3_pop");
`ifndef CSR_BYPASS_EN
    chk("t3_creg", 16'(bus_if.creg), 16'h0C);
    chk("t3_sreg", 16'(bus_if.sreg), 16'h08);
`endif
    chk("t3_empty", 16'(bus_if.ctx_empty), 16'h1);

    // 4: fill to full with distinct CRs, overflow, then restore in LIFO order
    do_reset("t4_rst");
    clr(); wr_cr(8'h01); cycle("t4_w1");
    for (int k = 2; k <= 5; k++) begin
      clr(); bus_if.ctx_push = 1'b1;
      if (k <= 4) wr_cr(8'(k));
      cycle($sformatf("t4_push%0d", k - 1));
    end
    chk("t4_full", 16'(bus_if.ctx_full), 16'h1);
    clr(); bus_if.ctx_push = 1'b1; cycle("t4_ovf");
    chk("t4_ovf_level", 16'(bus_if.ctx_level), 16'd4);
    chk("t4_ovf_err", 16'(bus_if.ctx_err), 16'h1);
    for (int k = 4; k >= 1; k--) begin
      clr(); bus_if.ctx_pop = 1'b1; cycle($sformatf("t4_pop%0d", k));
`ifndef CSR_BYPASS_EN
      chk($sformatf("t4_restore%0d", k), 16'(bus_if.creg), 16'(k));
`endif
    end

    // 5: underflow keeps CR; push&pop collision holds level
    do_reset("t5_rst");
    clr(); wr_cr(8'h5A); cycle("t5_wr");
    clr(); bus_if.ctx_pop = 1'b1; cycle("t5_unf");
`ifndef CSR_BYPASS_EN
    chk("t5_unf_creg", 16'(bus_if.creg), 16'h5A);
`endif
    chk("t5_unf_err", 16'(bus_if.ctx_err), 16'h1);
    do_reset("t5_rst2");
    clr(); bus_if.ctx_push = 1'b1; cycle("t5_p1");
    cycle("t5_p2");
    bus_if.ctx_pop = 1'b1; cycle("t5_coll");
    chk("t5_coll_level", 16'(bus_if.ctx_level), 16'd2);
    chk("t5_coll_err", 16'(bus_if.ctx_err), 16'h1);

    // 6: sticky HW event during restore is not lost
    do_reset("t6_rst");
    clr(); bus_if.ctx_push = 1'b1; cycle("t6_push");
    clr(); bus_if.ctx_pop = 1'b1;
    bus_if.hw_sr_en = 8'(1 << SR_STOVF); bus_if.hw_sr_val = 8'(1 << SR_STOVF);
    cycle("t6_pop");
`ifndef CSR_BYPASS_EN
    chk("t6_sreg", 16'(bus_if.sreg), 16'h02);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      clr();
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        bus_if.hw_sr_en  = 8'($urandom & $urandom);
        bus_if.hw_sr_val = 8'($urandom);
        bus_if.hw_cr_en  = 8'($urandom & $urandom);
        bus_if.hw_cr_val = 8'($urandom);
        bus_if.sw_wr     = ($urandom_range(0, 2) == 0);
        bus_if.sw_sel    = 1'($urandom);
        bus_if.sw_data   = 8'($urandom);
        bus_if.sw_mask   = 8'($urandom);
        r = $urandom_range(0, 9);
        bus_if.ctx_push  = (r <= 2) || (r == 6);
        bus_if.ctx_pop   = (r >= 3 && r <= 6);
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
